// File: rtl/tx_dll_pkg.sv
// Shared constants, FSM state type and LCRC helper for the TX data link layer.
package tx_dll_pkg;

   localparam int unsigned SEQ_W   = 12;
   localparam int unsigned DATA_W  = 1024;
   localparam int unsigned ENTRY_W = DATA_W + SEQ_W;

   localparam logic [7:0] DLLP_ACK = 8'h00;
   localparam logic [7:0] DLLP_NAK = 8'h10;

   typedef enum logic {
      SEND,
      REPLAY
   } dll_state_t;

   // LCRC: XOR of all 32-bit payload words, folded with the zero-extended sequence number.
   function automatic logic [31:0] lcrc_calc(input logic [DATA_W-1:0] data,
                                             input logic [SEQ_W-1:0]  seq);
      logic [31:0] acc;
      acc = {{(32-SEQ_W){1'b0}}, seq};
      for (int unsigned i = 0; i < DATA_W / 32; i++) begin
         acc = acc ^ data[i*32 +: 32];
      end
      return acc;
   endfunction

endpackage

// File: rtl/tx_replay_buffer.sv
// Replay buffer storage: one synchronous write port, one asynchronous read port.
module tx_replay_buffer
   import tx_dll_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [ENTRY_W-1:0]       wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [ENTRY_W-1:0]       rd_data
);

   logic [ENTRY_W-1:0] mem [DEPTH];

   // Capture an accepted TLP together with its sequence number.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tx_data_link_layer.sv
// TX data link layer: sequence numbering, LCRC, replay buffer with ACK/NAK and timeout replay.
module tx_data_link_layer
   import tx_dll_pkg::*;
#(
   parameter int unsigned REPLAY_DEPTH   = 4,
   parameter int unsigned REPLAY_TIMEOUT = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tlp_data_in,
   input  logic              tlp_data_in_valid,
   output logic              tlp_data_in_ready,
   output logic [DATA_W-1:0] tx_tlp_data,
   output logic [SEQ_W-1:0]  tx_tlp_seq,
   output logic [31:0]       tx_tlp_lcrc,
   output logic              tx_tlp_valid,
   input  logic              tx_tlp_ready,
   input  logic [31:0]       dllp_in,
   input  logic              dllp_in_valid,
   output logic              replay_err
);

   localparam int unsigned AW = $clog2(REPLAY_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned TW = $clog2(REPLAY_TIMEOUT);

   dll_state_t       state;
   logic [PW-1:0]    ack_ptr, send_ptr, wr_ptr, replay_end;
   logic [SEQ_W-1:0] next_seq, ackd_seq;
   logic [TW-1:0]    timer;
   logic [1:0]       replay_num;

   logic [PW-1:0]    count, outstanding, purge, ack_next, send_adv;
   logic             full, accept, tx_hs;
   logic             is_ack, is_nak, dllp_ok, timeout_hit, replay_start;
   logic [SEQ_W-1:0] ack_dist;
   logic [1:0]       rnum_base;
   logic [ENTRY_W-1:0] rd_entry;
   logic             dllp_unused;

   tx_replay_buffer #(
      .DEPTH (REPLAY_DEPTH)
   ) u_buf (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data ({tlp_data_in, next_seq}),
      .rd_addr (send_ptr[AW-1:0]),
      .rd_data (rd_entry)
   );

   assign count       = wr_ptr - ack_ptr;
   assign full        = (count == PW'(REPLAY_DEPTH));
   assign outstanding = send_ptr - ack_ptr;

   // Reset gating keeps both handshakes closed while reset is asserted.
   assign tlp_data_in_ready = !reset && !full && (state == SEND);
   assign tx_tlp_valid      = !reset && (send_ptr != wr_ptr);
   assign accept            = tlp_data_in_valid && tlp_data_in_ready;
   assign tx_hs             = tx_tlp_valid && tx_tlp_ready;

   assign tx_tlp_data = rd_entry[ENTRY_W-1:SEQ_W];
   assign tx_tlp_seq  = rd_entry[SEQ_W-1:0];
   assign tx_tlp_lcrc = lcrc_calc(tx_tlp_data, tx_tlp_seq);

   assign dllp_unused = ^dllp_in[23:12];
   assign is_ack      = dllp_in_valid && (dllp_in[31:24] == DLLP_ACK);
   assign is_nak      = dllp_in_valid && (dllp_in[31:24] == DLLP_NAK);
   assign ack_dist    = dllp_in[SEQ_W-1:0] - ackd_seq;
   assign dllp_ok     = (is_ack || is_nak) && (ack_dist != '0) &&
                        (ack_dist <= {{(SEQ_W-PW){1'b0}}, outstanding});
   assign purge       = dllp_ok ? ack_dist[PW-1:0] : '0;
   assign ack_next    = ack_ptr + purge;
   assign send_adv    = send_ptr + PW'(tx_hs);

   assign timeout_hit  = (state == SEND) && (send_ptr != ack_ptr) &&
                         (timer == TW'(REPLAY_TIMEOUT - 1));
   assign replay_start = is_nak || timeout_hit;
   // A valid ACK/NAK clears the replay count before a same-cycle replay bumps it.
   assign rnum_base    = dllp_ok ? 2'd0 : replay_num;

   // Pointer, sequence, timer and SEND/REPLAY control with registered replay_err.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= SEND;
         ack_ptr    <= '0;
         send_ptr   <= '0;
         wr_ptr     <= '0;
         replay_end <= '0;
         next_seq   <= '0;
         ackd_seq   <= '1;
         timer      <= '0;
         replay_num <= '0;
         replay_err <= 1'b0;
      end else begin
         replay_err <= 1'b0;
         ack_ptr    <= ack_next;
         if (dllp_ok) begin
            ackd_seq <= dllp_in[SEQ_W-1:0];
         end
         if (accept) begin
            wr_ptr   <= wr_ptr + PW'(1);
            next_seq <= next_seq + SEQ_W'(1);
         end
         if (replay_start || dllp_ok) begin
            timer <= '0;
         end else if ((state == SEND) && (send_ptr != ack_ptr)) begin
            timer <= timer + TW'(1);
         end else begin
            timer <= '0;
         end
         if (replay_start) begin
            // Rewind overrides any same-cycle tx handshake; the end mark is the cursor before this edge.
            send_ptr   <= ack_next;
            replay_end <= send_ptr;
            state      <= REPLAY;
            if (rnum_base == 2'd3) begin
               replay_num <= 2'd0;
               replay_err <= 1'b1;
            end else begin
               replay_num <= rnum_base + 2'd1;
            end
         end else begin
            send_ptr <= send_adv;
            if (dllp_ok) begin
               replay_num <= 2'd0;
            end
            // Also leave REPLAY when the cursor already sits on the end mark (empty replay window).
            if ((state == REPLAY) && ((send_ptr == replay_end) || (send_adv == replay_end))) begin
               state <= SEND;
            end
         end
      end
   end

endmodule
